conv_frame_loader: RTL and testbench
====================================

// Module: conv_frame_loader
// PURPOSE
//  Stream-side front/back end for the 3x3 convolution engine (flat DIM*DIM matrix, start/done handshake).
//  Collects DIM*DIM pixels from a valid/ready input stream into the engine's flat input matrix and pulses start.
//  Captures the output matrix on done and replays it as a valid/ready output stream, row-major.
//  Replaces testbench-style direct matrix driving in the integrated design.
// PARAMETERS
//  DIM        9      matrix side; frame = DIM*DIM pixels
//  PIX_W      8      bits per pixel
//  TMO_CYC    4096   watchdog limit in cycles, WAIT state only (used only with CONV_TIMEOUT_EN)
// PORTS
//  clk         in   1               system clock, rising edge
//  rst         in   1               async reset, active-low
//  s_valid     in   1               input pixel valid
//  s_ready     out  1               input pixel accept
//  s_data      in   PIX_W           input pixel, row-major order
//  conv_start  out  1               one-cycle start pulse to engine
//  conv_in     out  DIM*DIM*PIX_W   engine input matrix; pixel k at [k*PIX_W +: PIX_W]
//  conv_done   in   1               engine done (level)
//  conv_out    in   DIM*DIM*PIX_W   engine output matrix, same packing
//  m_valid     out  1               output pixel valid
//  m_ready     in   1               output pixel accept
//  m_data      out  PIX_W           output pixel
//  m_last      out  1               high with final pixel (k = DIM*DIM-1)
//  busy        out  1               high in START/WAIT/DRAIN
//  tmo_err     out  1               sticky watchdog flag (tied 0 without CONV_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=LOAD, idx=0, conv_in=0, out_buf=0, conv_start=0, m_valid=0, m_last=0, busy=0, tmo_err=0, done_q=0.
//  Single index counter idx (0..DIM*DIM-1) shared by LOAD and DRAIN; cleared on every state exit.
//  LOAD:  s_ready=1. On s_valid&&s_ready write s_data to conv_in[idx]; idx++. Accept at idx=DIM*DIM-1 -> START.
//  START: s_ready=0; conv_start=1 for exactly this cycle -> WAIT.
//  WAIT:  done_q <= conv_done every cycle. Capture on rising edge (conv_done && !done_q):
//         out_buf <= conv_out, -> DRAIN. Stale done held high from prior frame is not accepted.
//  DRAIN: m_valid=1, m_data=out_buf[idx], m_last=(idx==DIM*DIM-1). Advance idx on m_valid&&m_ready.
//         Last beat accepted -> LOAD (idx=0). m_data/m_last stable while m_valid&&!m_ready.
//  Latency: conv_start asserted 1 cycle after 81st input accept; m_valid 1 cycle after done rising edge.
//  Throughput: 1 pixel/cycle both streams; no overlap between LOAD of frame N+1 and DRAIN of frame N.
//  conv_in held stable from START until next LOAD write; s_ready=0 and input ignored outside LOAD.
//  Reset mid-frame: partial frame discarded, all state as reset; engine must be reset alongside.
// CONFIGURATION
//  CONV_TIMEOUT_EN defined: cycle counter runs in WAIT; reaching TMO_CYC sets tmo_err (sticky until reset),
//   out_buf <= 0, -> DRAIN (frame of zeros emitted so downstream stays aligned).
//  CONV_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; tmo_err tied 0.
// STRUCTURE
//  Shared package conv_pkg: DIM, PIX_W, FRAME_PIX=DIM*DIM, MAT_W=FRAME_PIX*PIX_W, IDX_W=$clog2(FRAME_PIX),
//   state encoding LOAD/START/WAIT/DRAIN.
//  Sub-module conv_pix_mux: combinational MAT_W -> PIX_W selector by idx (feeds m_data).
//  Everything else in one always_ff FSM + datapath.
// TESTING (bench engine model: conv_out = conv_in ^ {FRAME_PIX{8'hFF}}, done rises 3 cycles after start, held 2)
//  Ramp 0..80, s_valid=1, m_ready=1 -> single conv_start; m_data 255,254..175; m_last only on 175.
//  s_valid toggled every other cycle -> conv_in identical to ramp case; start only after 81st accept.
//  m_ready low 5 cycles at beat 10 -> m_data=245 held stable, no beat dropped or duplicated.
//  Two back-to-back frames (ramp, then all 8'h10) -> second output all 8'hEF; stale done ignored.
//  rst low at input beat 40, then full ramp -> exactly one frame output, matches first scenario.
//  CONV_TIMEOUT_EN, TMO_CYC=16, engine never asserts done -> tmo_err=1, 81 zero pixels, then LOAD.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared geometry and FSM encoding for the convolution stream loader.
// Every width below is derived from DIM and PIX_W.
package conv_pkg;

    localparam int DIM       = 9;
    localparam int PIX_W     = 8;
    localparam int FRAME_PIX = DIM * DIM;
    localparam int MAT_W     = FRAME_PIX * PIX_W;
    localparam int IDX_W     = $clog2(FRAME_PIX);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/conv_pix_mux.sv
// Picks pixel idx_i out of a flat row-major matrix.
// Purely combinational, zero latency, no flow control.
module conv_pix_mux
    import conv_pkg::*;
(
    input  logic [MAT_W-1:0] mat_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [PIX_W-1:0] pix_o
);

    assign pix_o = mat_i[idx_i*PIX_W +: PIX_W];

endmodule

// File: rtl/conv_frame_loader.sv
// Stream <-> flat-matrix bridge for the conv engine; optional watchdog via CONV_TIMEOUT_EN.
// Latency: start 1 cycle after last input accept, m_valid 1 cycle after done rises; s_ready only in LOAD, m_data held while !m_ready.
module conv_frame_loader
    import conv_pkg::*;
#(
    parameter int TMO_CYC = 4096
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             conv_start,
    output logic [MAT_W-1:0] conv_in,
    input  logic             conv_done,
    input  logic [MAT_W-1:0] conv_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             tmo_err
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MAT_W-1:0] conv_in_q, conv_in_d;
    logic [MAT_W-1:0] out_buf_q, out_buf_d;
    logic             done_q;
    logic             done_rise;
    logic             tmo_hit;

    // done_q tracks the level in every state, so a done still high from the
    // previous frame is seen as already-high when WAIT is entered.
    assign done_rise = conv_done && !done_q;

`ifdef CONV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q;

    assign tmo_hit   = (state_q == ST_WAIT) && !done_rise &&
                       (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
    assign tmo_cnt_d = ((state_q == ST_WAIT) && (state_d == ST_WAIT)) ?
                       tmo_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end

    assign tmo_err = tmo_err_q;
`else
    logic unused_tmo;

    assign unused_tmo = ^TMO_CYC;
    assign tmo_hit    = 1'b0;
    assign tmo_err    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        conv_in_d  = conv_in_q;
        out_buf_d  = out_buf_q;
        s_ready    = 1'b0;
        conv_start = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        busy       = 1'b1;

        case (state_q)
            ST_LOAD: begin
                busy    = 1'b0;
                s_ready = 1'b1;
                if (s_valid) begin
                    conv_in_d[idx_q*PIX_W +: PIX_W] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                conv_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    out_buf_d = conv_out;
                    state_d   = ST_DRAIN;
                end else if (tmo_hit) begin
                    // Emit a zero frame so downstream framing stays aligned.
                    out_buf_d = '0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                m_valid = 1'b1;
                m_last  = (idx_q == LAST_IDX);
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            conv_in_q <= '0;
            out_buf_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            conv_in_q <= conv_in_d;
            out_buf_q <= out_buf_d;
            done_q    <= conv_done;
        end
    end

    assign conv_in = conv_in_q;

    conv_pix_mux u_pix_mux (
        .mat_i (out_buf_q),
        .idx_i (idx_q),
        .pix_o (m_data)
    );

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader with a behavioural engine (out = in ^ 0xFF).
// Define CONV_TIMEOUT_EN to also exercise the watchdog path.
module tb_conv_frame_loader;
    import conv_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [PIX_W-1:0] s_data = '0;
    logic             conv_start;
    logic [MAT_W-1:0] conv_in;
    logic             conv_done = 1'b0;
    logic [MAT_W-1:0] conv_out = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [PIX_W-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             tmo_err;

    logic [MAT_W-1:0] ramp_mat;
    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;

    int   eng_t = 0;
    logic eng_run = 1'b0;
    logic eng_en = 1'b1;
    int   eng_pre_fall = 0;
    int   eng_rise = 3;
    int   eng_fall = 5;

    always #5 clk = ~clk;

    conv_frame_loader #(.TMO_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .conv_start (conv_start),
        .conv_in    (conv_in),
        .conv_done  (conv_done),
        .conv_out   (conv_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    // Engine model: schedule measured in negedges after the start cycle.
    always @(negedge clk) begin
        if (conv_start) begin
            eng_t     = 0;
            eng_run   = 1'b1;
            start_cnt = start_cnt + 1;
        end else if (eng_run) begin
            eng_t = eng_t + 1;
            if (eng_t == eng_pre_fall) conv_done = 1'b0;
            if (eng_t == eng_rise && eng_en) begin
                conv_out  = conv_in ^ {FRAME_PIX{8'hFF}};
                conv_done = 1'b1;
            end
            if (eng_t == eng_fall) begin
                conv_done = 1'b0;
                eng_run   = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed time %0t required finish", $time);
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int mode, input int k);
        if (mode == 0) return 8'(255 - k);
        if (mode == 1) return 8'hEF;
        return 8'h00;
    endfunction

    // Called at a negedge; returns at the negedge after the n-th accept.
    task automatic send_frame(input int mode, input int gap, input int n);
        int k = 0;
        int g = 0;
        while (k < n && g < 3000) begin
            s_valid = (gap == 0) ? 1'b1 : ((g % 2) == 0);
            s_data  = (mode == 0) ? 8'(k) : 8'h10;
            if (s_valid && s_ready) k++;
            @(negedge clk);
            g++;
        end
        s_valid = 1'b0;
        chk("send_beats", k, n);
    endtask

    // Called at a negedge; returns at the negedge after the last beat is taken.
    task automatic recv_frame(input int mode, input int stall_at);
        int k = 0;
        int g = 0;
        int stall = 5;
        while (k < FRAME_PIX && g < 3000) begin
            if (m_valid) begin
                if (k == stall_at && stall > 0) begin
                    m_ready = 1'b0;
                    stall--;
                    chk("stall_data", m_data, exp_pix(mode, k));
                    chk("stall_last", m_last, 0);
                end else begin
                    m_ready = 1'b1;
                    chk($sformatf("m_data[%0d]", k), m_data, exp_pix(mode, k));
                    chk($sformatf("m_last[%0d]", k), m_last, (k == FRAME_PIX - 1));
                    k++;
                end
            end else begin
                m_ready = 1'b1;
            end
            @(negedge clk);
            g++;
        end
        chk("recv_beats", k, FRAME_PIX);
        chk("post_m_valid", m_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_s_ready", s_ready, 1);
    endtask

    initial begin
        int s0;
        int extra;
        for (int k = 0; k < FRAME_PIX; k++) ramp_mat[k*PIX_W +: PIX_W] = 8'(k);

        // Reset state
        #2 rst = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_start", conv_start, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_s_ready", s_ready, 1);
        chk_mat("rst_conv_in", conv_in, '0);
        @(negedge clk);
        rst = 1'b1;

        // Ramp frame, continuous streams, latency and input-ignored checks
        s0 = start_cnt;
        send_frame(0, 0, FRAME_PIX);
        chk("s1_start_pulse", conv_start, 1);
        chk("s1_s_ready_start", s_ready, 0);
        chk("s1_busy", busy, 1);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        @(negedge clk);
        chk("s1_start_single", conv_start, 0);
        chk("s1_no_early_valid1", m_valid, 0);
        @(negedge clk);
        chk("s1_no_early_valid2", m_valid, 0);
        @(negedge clk);
        chk("s1_no_early_valid3", m_valid, 0);
        m_ready = 1'b1;
        @(negedge clk);
        chk("s1_valid_latency", m_valid, 1);
        s_valid = 1'b0;
        chk_mat("s1_conv_in_held", conv_in, ramp_mat);
        recv_frame(0, -1);
        chk("s1_start_count", start_cnt, s0 + 1);

        // Toggled input valid
        s0 = start_cnt;
        send_frame(0, 1, FRAME_PIX);
        chk("s2_start_pulse", conv_start, 1);
        chk_mat("s2_conv_in", conv_in, ramp_mat);
        recv_frame(0, -1);
        chk("s2_start_count", start_cnt, s0 + 1);

        // Output backpressure at beat 10
        send_frame(0, 0, FRAME_PIX);
        recv_frame(0, 10);

        // Back-to-back frames with done left high across the second start
        eng_pre_fall = 0;
        eng_rise     = 3;
        eng_fall     = 100000;
        send_frame(0, 0, FRAME_PIX);
        recv_frame(0, -1);
        eng_pre_fall = 5;
        eng_rise     = 8;
        eng_fall     = 10;
        send_frame(1, 0, FRAME_PIX);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("s4_stale_wait[%0d]", i), m_valid, 0);
        end
        recv_frame(1, -1);
        eng_pre_fall = 0;
        eng_rise     = 3;
        eng_fall     = 5;

        // Reset mid-load, then a full ramp
        send_frame(0, 0, 40);
        rst = 1'b0;
        #1;
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_s_ready", s_ready, 1);
        chk_mat("s5_rst_conv_in", conv_in, '0);
        @(negedge clk);
        rst = 1'b1;
        s0 = start_cnt;
        send_frame(0, 0, FRAME_PIX);
        chk_mat("s5_conv_in", conv_in, ramp_mat);
        recv_frame(0, -1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) extra++;
        end
        chk("s5_extra_beats", extra, 0);
        chk("s5_start_count", start_cnt, s0 + 1);

`ifdef CONV_TIMEOUT_EN
        // Engine never answers: watchdog emits a zero frame
        chk("s6_tmo_before", tmo_err, 0);
        eng_en = 1'b0;
        send_frame(0, 0, FRAME_PIX);
        recv_frame(2, -1);
        chk("s6_tmo_sticky", tmo_err, 1);
        eng_en = 1'b1;
`else
        chk("tmo_tied_low", tmo_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
